// File: rtl/cache_line_fetcher.sv
// cache_line_fetcher: refill engine for the LRU cache backend.
// Takes one miss tag, issues one AXI-style burst read of BEATS beats,
// assembles the beats into a cache line and returns it with its tag.
// Optional macro FETCH_TIMEOUT_EN adds a DATA-phase watchdog plus a DRAIN
// state that swallows the rest of an abandoned burst.
module cache_line_fetcher #(
  parameter int TAGS_WIDTH     = 48,
  parameter int CACHE_SIZE     = 512,
  parameter int MEM_DATA_WIDTH = 128,
  parameter int ADDR_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_tvalid,
  output logic                      req_tready,
  input  logic [TAGS_WIDTH-1:0]     req_tdata,
  output logic                      rsp_tvalid,
  input  logic                      rsp_tready,
  output logic [CACHE_SIZE-1:0]     rsp_tdata,
  output logic [TAGS_WIDTH-1:0]     rsp_tuser,
  output logic                      rsp_terr,
  output logic                      mem_arvalid,
  input  logic                      mem_arready,
  output logic [ADDR_WIDTH-1:0]     mem_araddr,
  output logic [7:0]                mem_arlen,
  input  logic                      mem_rvalid,
  output logic                      mem_rready,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata,
  input  logic                      mem_rlast
);

  localparam int BEATS = CACHE_SIZE / MEM_DATA_WIDTH;
  localparam int OFS   = $clog2(CACHE_SIZE / 8);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  // Reject configurations the line assembly cannot represent.
  if ((CACHE_SIZE % MEM_DATA_WIDTH) != 0 || BEATS > 256 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("cache_line_fetcher: invalid parameter combination");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
`ifdef FETCH_TIMEOUT_EN
    RESP,
    DRAIN
`else
    RESP
`endif
  } state_t;

  state_t                    state_q, state_d;
  logic [TAGS_WIDTH-1:0]     tag_q, tag_d;
  logic [CACHE_SIZE-1:0]     line_q, line_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_q, err_d;
  logic [ADDR_WIDTH-1:0]     araddr_q, araddr_d;
  logic [7:0]                arlen_q, arlen_d;
  logic                      req_tready_q, req_tready_d;
  logic                      rsp_tvalid_q, rsp_tvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
`ifdef FETCH_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      to_q, to_d;
`endif

  // Handshakes are qualified by the registered ready/valid the block drives,
  // so the first cycle after reset (req_tready still 0) cannot accept a tag.
  logic req_hs, ar_hs, r_hs, rsp_hs;
  assign req_hs = req_tvalid & req_tready_q;
  assign ar_hs  = arvalid_q & mem_arready;
  assign r_hs   = mem_rvalid & rready_q;
  assign rsp_hs = rsp_tvalid_q & rsp_tready;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
`ifdef FETCH_TIMEOUT_EN
    wd_d     = wd_q;
    to_d     = to_q;
`endif
    case (state_q)
      IDLE: if (req_hs) begin
        tag_d    = req_tdata;
        // Line byte address; the cast truncates or zero-extends as needed.
        araddr_d = ADDR_WIDTH'({req_tdata, {OFS{1'b0}}});
        arlen_d  = 8'(BEATS - 1);
        line_d   = '0;
        cnt_d    = '0;
        err_d    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        to_d     = 1'b0;
`endif
        state_d  = ADDR;
      end
      ADDR: if (ar_hs) begin
`ifdef FETCH_TIMEOUT_EN
        wd_d    = WD_W'(1);
`endif
        state_d = DATA;
      end
      DATA: begin
        if (r_hs) begin
          line_d[cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef FETCH_TIMEOUT_EN
          wd_d  = WD_W'(1);
`endif
          if (cnt_q == LAST_BEAT) begin
            // Full count reached: leave regardless, flag a missing rlast.
            err_d   = err_q | ~mem_rlast;
            state_d = RESP;
          end else if (mem_rlast) begin
            // Short burst: unwritten line bits stay zero.
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          // wd counts the stalled cycle now starting, including itself.
          wd_d = wd_q + WD_W'(1);
          if (wd_d == WD_W'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            to_d    = 1'b1;
            state_d = RESP;
          end
        end
`endif
      end
      RESP: if (rsp_hs) begin
`ifdef FETCH_TIMEOUT_EN
        state_d = to_q ? DRAIN : IDLE;
`else
        state_d = IDLE;
`endif
      end
`ifdef FETCH_TIMEOUT_EN
      DRAIN: if (r_hs && mem_rlast) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    req_tready_d = (state_d == IDLE);
    arvalid_d    = (state_d == ADDR);
    rsp_tvalid_d = (state_d == RESP);
`ifdef FETCH_TIMEOUT_EN
    rready_d     = (state_d == DATA) || (state_d == DRAIN);
`else
    rready_d     = (state_d == DATA);
`endif
  end

  // State and output registers; reset abandons any fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tag_q        <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      req_tready_q <= 1'b0;
      rsp_tvalid_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wd_q         <= '0;
      to_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      req_tready_q <= req_tready_d;
      rsp_tvalid_q <= rsp_tvalid_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
`ifdef FETCH_TIMEOUT_EN
      wd_q         <= wd_d;
      to_q         <= to_d;
`endif
    end
  end

  assign req_tready  = req_tready_q;
  assign rsp_tvalid  = rsp_tvalid_q;
  assign rsp_tdata   = line_q;
  assign rsp_tuser   = tag_q;
  assign rsp_terr    = err_q;
  assign mem_arvalid = arvalid_q;
  assign mem_araddr  = araddr_q;
  assign mem_arlen   = arlen_q;
  assign mem_rready  = rready_q;

endmodule

// File: tb/tb_cache_line_fetcher.sv
// Self-checking bench for cache_line_fetcher (default 48/512/128/64 config).
// Memory and downstream are driven from tasks; expected lines, addresses,
// error flags and latencies come from a small behavioural model.
module tb_cache_line_fetcher;
  localparam int BEATS = 4;
  localparam int LIM   = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_tvalid = 1'b0, req_tready;
  logic [47:0]  req_tdata = '0;
  logic         rsp_tvalid, rsp_tready = 1'b0;
  logic [511:0] rsp_tdata;
  logic [47:0]  rsp_tuser;
  logic         rsp_terr;
  logic         mem_arvalid, mem_arready = 1'b0;
  logic [63:0]  mem_araddr;
  logic [7:0]   mem_arlen;
  logic         mem_rvalid = 1'b0, mem_rready;
  logic [127:0] mem_rdata = '0;
  logic         mem_rlast = 1'b0;

  int checks = 0, errors = 0;
  int cyc = 0, req_hs = 0, rsp_hs = 0, vld_rise = 0, beat_hs = 0;
  logic vld_prev = 1'b0;

  cache_line_fetcher #(
    .TAGS_WIDTH(48), .CACHE_SIZE(512), .MEM_DATA_WIDTH(128),
    .ADDR_WIDTH(64), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_tvalid(req_tvalid), .req_tready(req_tready), .req_tdata(req_tdata),
    .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tdata(rsp_tdata),
    .rsp_tuser(rsp_tuser), .rsp_terr(rsp_terr),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
    .mem_arlen(mem_arlen), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
    .mem_rdata(mem_rdata), .mem_rlast(mem_rlast)
  );

  always #5 clk = ~clk;

  // Edge-numbered record of handshakes and the first cycle rsp_tvalid is seen.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_tvalid && req_tready) req_hs <= cyc;
    if (rsp_tvalid && rsp_tready) rsp_hs <= cyc;
    if (mem_rvalid && mem_rready) beat_hs <= cyc;
    if (rsp_tvalid && !vld_prev) vld_rise <= cyc;
    vld_prev <= rsp_tvalid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [47:0] rand_tag();
    return 48'({$urandom, $urandom});
  endfunction

  function automatic logic [63:0] line_addr(input logic [47:0] t);
    return 64'(t) * 64;  // 64-byte lines
  endfunction

  // One complete miss. nb beats are sent, rlast on beat index rl (-1: never).
  task automatic fetch(input logic [47:0] tag, input int ar_stall, input int gmin,
                       input int gmax, input int nb, input int rl, input int rsp_stall,
                       input bit fixed, input bit chk_lat, input bit b2b);
    logic [511:0] exp_line;
    logic [127:0] b;
    bit exp_err;
    int n, prev_rsp;
    exp_line = '0;
    exp_err  = !(nb == BEATS && rl == BEATS - 1);
    prev_rsp = rsp_hs;
    req_tvalid = 1'b1; req_tdata = tag;
    n = 0;
    while (!req_tready && n < LIM) begin @(negedge clk); n++; end
    check("req_wait", n < LIM, 1);
    @(negedge clk);
    req_tvalid = 1'b0; req_tdata = rand_tag();
    if (b2b) check("b2b_accept_gap", req_hs - prev_rsp, 1);
    n = 0;
    while (!mem_arvalid && n < LIM) begin @(negedge clk); n++; end
    check("arvalid", mem_arvalid, 1);
    check("araddr", mem_araddr, line_addr(tag));
    check("arlen", mem_arlen, BEATS - 1);
    check("req_busy_ar", req_tready, 0);
    repeat (ar_stall) begin
      @(negedge clk);
      check("araddr_hold", mem_araddr, line_addr(tag));
      check("arvalid_hold", mem_arvalid, 1);
    end
    mem_arready = 1'b1;
    @(negedge clk);
    mem_arready = 1'b0;
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(gmax, gmin)) begin
        @(negedge clk);
        check("req_busy_data", req_tready, 0);
      end
      b = fixed ? {32{4'(10 + k)}} : {$urandom, $urandom, $urandom, $urandom};
      mem_rvalid = 1'b1; mem_rdata = b; mem_rlast = (k == rl);
      n = 0;
      while (!mem_rready && n < LIM) begin @(negedge clk); n++; end
      check("rready", mem_rready, 1);
      @(negedge clk);
      exp_line[k*128 +: 128] = b;
      mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_rdata = '0;
    end
    n = 0;
    while (!rsp_tvalid && n < LIM) begin @(negedge clk); n++; end
    check("rsp_tvalid", rsp_tvalid, 1);
    check("rsp_tdata", rsp_tdata, exp_line);
    check("rsp_tuser", rsp_tuser, tag);
    check("rsp_terr", rsp_terr, exp_err);
    repeat (rsp_stall) begin
      @(negedge clk);
      check("rsp_hold_valid", rsp_tvalid, 1);
      check("rsp_hold_data", rsp_tdata, exp_line);
      check("rsp_hold_user", rsp_tuser, tag);
      check("req_busy_rsp", req_tready, 0);
    end
    rsp_tready = 1'b1;
    @(negedge clk);
    rsp_tready = 1'b0;
    if (chk_lat) check("latency", vld_rise - req_hs, BEATS + 2);
  endtask

  initial begin
    logic [47:0] t;
    logic [511:0] exp_line;
    logic [127:0] b;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {req_tready, rsp_tvalid, mem_arvalid, mem_rready, rsp_terr}, 0);
    check("rst_tdata", rsp_tdata, 0);
    check("rst_tuser", rsp_tuser, 0);
    check("rst_araddr", mem_araddr, 0);
    rst = 1'b0;
    #1 check("req_tready_pre_edge", req_tready, 0);
    @(negedge clk);
    check("req_tready_post_rst", req_tready, 1);

    // Basic fetch, no stalls, fixed A/B/C/D beats
    fetch(48'h000000001234, 0, 0, 0, 4, 3, 0, 1, 1, 0);
    // Backpressure on every channel
    fetch(rand_tag(), 5, 1, 2, 4, 3, 3, 0, 0, 0);
    // Early rlast on beat 1, then a normal fetch
    fetch(rand_tag(), 0, 0, 0, 2, 1, 0, 0, 0, 0);
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 0);
    // Back-to-back zero-wait fetches
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 0);
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 1);
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 1);

    // Reset in the middle of DATA
    t = rand_tag();
    req_tvalid = 1'b1; req_tdata = t;
    n = 0;
    while (!req_tready && n < LIM) begin @(negedge clk); n++; end
    @(negedge clk); req_tvalid = 1'b0;
    n = 0;
    while (!mem_arvalid && n < LIM) begin @(negedge clk); n++; end
    mem_arready = 1'b1; @(negedge clk); mem_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1; mem_rdata = {4{$urandom}};
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_ctrl", {req_tready, rsp_tvalid, mem_arvalid, mem_rready, rsp_terr}, 0);
    check("midrst_tdata", rsp_tdata, 0);
    check("midrst_tuser", rsp_tuser, 0);
    check("midrst_araddr", mem_araddr, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("req_tready_after_midrst", req_tready, 1);
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 0);

    // Randomised mix of stalls, short bursts and missing rlast
    for (int i = 0; i < 12; i++) begin
      int sel, nb, rl;
      sel = $urandom_range(3, 0);
      nb = 4; rl = 3;
      if (sel == 1) begin nb = $urandom_range(3, 1); rl = nb - 1; end
      else if (sel == 2) rl = -1;
      fetch(rand_tag(), $urandom_range(3, 0), 0, 2, nb, rl, $urandom_range(3, 0), 0, 0, 0);
    end

`ifdef FETCH_TIMEOUT_EN
    // Memory stalls after two beats; watchdog fires, late beats are drained
    t = rand_tag();
    exp_line = '0;
    req_tvalid = 1'b1; req_tdata = t;
    n = 0;
    while (!req_tready && n < LIM) begin @(negedge clk); n++; end
    @(negedge clk); req_tvalid = 1'b0;
    n = 0;
    while (!mem_arvalid && n < LIM) begin @(negedge clk); n++; end
    mem_arready = 1'b1; @(negedge clk); mem_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b = {$urandom, $urandom, $urandom, $urandom};
      mem_rvalid = 1'b1; mem_rdata = b;
      @(negedge clk);
      exp_line[k*128 +: 128] = b;
    end
    mem_rvalid = 1'b0;
    n = 0;
    while (!rsp_tvalid && n < LIM) begin @(negedge clk); n++; end
    check("to_rsp_tvalid", rsp_tvalid, 1);
    check("to_rsp_terr", rsp_terr, 1);
    check("to_rsp_tdata", rsp_tdata, exp_line);
    check("to_rsp_tuser", rsp_tuser, t);
    rsp_tready = 1'b1; @(negedge clk); rsp_tready = 1'b0;
    check("to_latency", vld_rise - beat_hs, 16);
    check("drain_rready", mem_rready, 1);
    check("drain_req_busy0", req_tready, 0);
    mem_rvalid = 1'b1; mem_rdata = {4{$urandom}}; mem_rlast = 1'b0;
    @(negedge clk);
    check("drain_req_busy1", req_tready, 0);
    mem_rlast = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rlast = 1'b0;
    check("drain_done_req_tready", req_tready, 1);
    fetch(rand_tag(), 0, 0, 0, 4, 3, 0, 0, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
